hilo_div: RTL and testbench

//  Multi-cycle radix-2 restoring divider serving the EX stage for DIV/DIVU.
//  EX is the initiator: it issues operands plus start_i, holds them, and stalls

---
 rtl/hilo_div_pkg.sv | 28 ++
 rtl/hilo_div.sv | 179 +++++++++++++++++
 tb/tb_hilo_div.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/hilo_div_pkg.sv
// rtl/hilo_div_pkg.sv - shared types and constants for the HI/LO divider
//
// Purpose: FSM state encoding for hilo_div plus the handshake levels and
// ALU opcodes the EX stage uses when talking to the divider.
// Ports: none (package).

package hilo_div_pkg;

    typedef enum logic [1:0] {
        FREE    = 2'b00,
        BY_ZERO = 2'b01,
        ON      = 2'b10,
        END     = 2'b11
    } div_state_t;

    // Levels of start_i as driven by EX.
    localparam logic DIV_START = 1'b1;
    localparam logic DIV_STOP  = 1'b0;

    // Levels of ready_o.
    localparam logic DIV_RESULT_READY     = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;

    // ALU opcodes that route an instruction to this block.
    localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
    localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

endpackage

// File: rtl/hilo_div.sv
// rtl/hilo_div.sv - multi-cycle radix-2 restoring divider for DIV/DIVU
//
// Purpose: EX raises start_i with operands and holds it until ready_o; the
// divider returns {remainder, quotient} on result_o, one divide in flight.
// Ports:
//   clk           clock, rising edge
//   rst_n         asynchronous active-low reset
//   signed_div_i  1 = signed DIV, 0 = DIVU (sampled on accept)
//   opdata1_i     dividend (sampled on accept)
//   opdata2_i     divisor (sampled on accept)
//   start_i       request, held by EX until it consumes the result
//   annul_i       cancels a divide in progress
//   result_o      {remainder, quotient}
//   ready_o       result_o valid

module hilo_div
    import hilo_div_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  signed_div_i,
    input  logic [DATA_W-1:0]     opdata1_i,
    input  logic [DATA_W-1:0]     opdata2_i,
    input  logic                  start_i,
    input  logic                  annul_i,
    output logic [2*DATA_W-1:0]   result_o,
    output logic                  ready_o
);

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W);

    div_state_t state, state_next;

    logic [CNT_W-1:0]    cnt;
    // {remainder (DATA_W+1 bits), dividend/quotient (DATA_W bits)}.
    // The quotient fills in from the bottom as the dividend shifts out the top.
    logic [2*DATA_W:0]   shreg;
    logic [DATA_W-1:0]   divisor;
    logic                sign1;
    logic                sign2;

    // Operand magnitudes, taken only for signed divides.
    logic                op1_neg;
    logic                op2_neg;
    logic [DATA_W-1:0]   op1_abs;
    logic [DATA_W-1:0]   op2_abs;
    logic                accept;

    assign op1_neg = signed_div_i & opdata1_i[DATA_W-1];
    assign op2_neg = signed_div_i & opdata2_i[DATA_W-1];
    assign op1_abs = op1_neg ? (DATA_W'(0) - opdata1_i) : opdata1_i;
    assign op2_abs = op2_neg ? (DATA_W'(0) - opdata2_i) : opdata2_i;
    assign accept  = start_i & ~annul_i;

    // One restoring step: trial-subtract the divisor from {rem, next dividend bit}.
    // The remainder is always below the divisor, so the partial fits DATA_W+1
    // bits and the extra top bit of diff is a pure borrow flag.
    logic [DATA_W+1:0]   partial;
    logic [DATA_W+1:0]   diff;
    logic [2*DATA_W:0]   shreg_step;

    assign partial = shreg[2*DATA_W:DATA_W-1];
    assign diff    = partial - {2'b00, divisor};

    always_comb begin
        shreg_step = {shreg[2*DATA_W-1:0], 1'b0};
        if (!diff[DATA_W+1]) begin
            shreg_step = {diff[DATA_W:0], shreg[DATA_W-2:0], 1'b1};
        end
    end

    // Sign correction: quotient negative iff signs differ, remainder follows
    // the dividend. 0x80..0 / -1 wraps naturally to 0x80..0.
    logic [DATA_W-1:0]   q_raw;
    logic [DATA_W-1:0]   r_raw;
    logic [DATA_W-1:0]   q_fix;
    logic [DATA_W-1:0]   r_fix;

    assign q_raw = shreg[DATA_W-1:0];
    assign r_raw = shreg[2*DATA_W-1:DATA_W];
    assign q_fix = (sign1 ^ sign2) ? (DATA_W'(0) - q_raw) : q_raw;
    assign r_fix = sign1 ? (DATA_W'(0) - r_raw) : r_raw;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FREE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            FREE: begin
                if (accept) begin
                    state_next = (opdata2_i == '0) ? BY_ZERO : ON;
                end
            end
            BY_ZERO: begin
                state_next = END;
            end
            ON: begin
                if (annul_i) begin
                    state_next = FREE;
                end else if (cnt == CNT_LAST) begin
                    state_next = END;
                end
            end
            END: begin
                if (!start_i) begin
                    state_next = FREE;
                end
            end
            default: begin
                state_next = FREE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            shreg    <= '0;
            divisor  <= '0;
            sign1    <= 1'b0;
            sign2    <= 1'b0;
            result_o <= '0;
            ready_o  <= DIV_RESULT_NOT_READY;
        end else begin
            case (state)
                FREE: begin
                    result_o <= '0;
                    ready_o  <= DIV_RESULT_NOT_READY;
                    if (accept && (opdata2_i != '0)) begin
                        cnt     <= '0;
                        shreg   <= {{(DATA_W+1){1'b0}}, op1_abs};
                        divisor <= op2_abs;
                        sign1   <= op1_neg;
                        sign2   <= op2_neg;
                    end
                end
                BY_ZERO: begin
                    // Zero divisor: no trap, result fixed at zero. ready_o rises
                    // from END on the following edge.
                    result_o <= '0;
                    ready_o  <= DIV_RESULT_NOT_READY;
                end
                ON: begin
                    if (!annul_i) begin
                        if (cnt == CNT_LAST) begin
                            result_o <= {r_fix, q_fix};
                            ready_o  <= DIV_RESULT_READY;
                        end else begin
                            shreg <= shreg_step;
                            cnt   <= cnt + 1'b1;
                        end
                    end
                end
                END: begin
                    if (start_i) begin
                        ready_o <= DIV_RESULT_READY;
                    end else begin
                        ready_o  <= DIV_RESULT_NOT_READY;
                        result_o <= '0;
                    end
                end
                default: begin
                    result_o <= '0;
                    ready_o  <= DIV_RESULT_NOT_READY;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_div.sv
// tb/tb_hilo_div.sv - directed self-checking bench for hilo_div

module tb_hilo_div;

    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           signed_div = 1'b0;
    logic [W-1:0]   op1 = '0;
    logic [W-1:0]   op2 = '0;
    logic           start = 1'b0;
    logic           annul = 1'b0;
    logic [2*W-1:0] result;
    logic           ready;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    hilo_div #(.DATA_W(W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .signed_div_i (signed_div),
        .opdata1_i    (op1),
        .opdata2_i    (op2),
        .start_i      (start),
        .annul_i      (annul),
        .result_o     (result),
        .ready_o      (ready)
    );

    // Full divide transaction: accept, measure latency in edges after the
    // accept edge, check result, hold, then release and check clear.
    task automatic do_div(input logic sg, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [2*W-1:0] exp, input int exp_lat, input string name);
        int k;
        logic timeout;
        @(negedge clk);
        signed_div = sg; op1 = a; op2 = b; annul = 1'b0; start = 1'b1;
        @(posedge clk);
        k = 0;
        timeout = 1'b1;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk);
            k++;
            @(negedge clk);
            if (k == 1) begin
                op1 = ~a; op2 = b ^ 32'h5; signed_div = ~sg;
            end
            if (ready) begin
                timeout = 1'b0;
                break;
            end
        end
        total++;
        if (timeout || k != exp_lat)
            $display("FAIL %s latency: got %0d edges (timeout=%0b), expected %0d", name, k, timeout, exp_lat);
        else passed++;
        total++;
        if (result !== exp)
            $display("FAIL %s result: got %h, expected %h", name, result, exp);
        else passed++;
        repeat (2) @(negedge clk);
        total++;
        if (ready !== 1'b1 || result !== exp)
            $display("FAIL %s hold: ready=%b result=%h, expected ready=1 result=%h", name, ready, result, exp);
        else passed++;
        start = 1'b0;
        @(negedge clk);
        total++;
        if (ready !== 1'b0 || result !== '0)
            $display("FAIL %s release: ready=%b result=%h, expected ready=0 result=0", name, ready, result);
        else passed++;
    endtask

    task automatic test_reset();
        #2;
        total++;
        if (ready !== 1'b0 || result !== '0)
            $display("FAIL reset: ready=%b result=%h, expected 0/0", ready, result);
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if (ready !== 1'b0 || result !== '0)
            $display("FAIL reset_idle: ready=%b result=%h, expected 0/0", ready, result);
        else passed++;
    endtask

    task automatic test_divu();
        do_div(1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33, "divu_100_7");
    endtask

    task automatic test_signed();
        do_div(1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33, "div_m7_2");
        do_div(1'b1, 32'd7, 32'hFFFF_FFFE, {32'd1, 32'hFFFF_FFFD}, 33, "div_7_m2");
    endtask

    task automatic test_by_zero();
        do_div(1'b0, 32'd5, 32'd0, 64'd0, 2, "divu_by_zero");
        do_div(1'b1, 32'd5, 32'd0, 64'd0, 2, "div_by_zero");
    endtask

    task automatic test_annul();
        logic saw_ready;
        saw_ready = 1'b0;
        @(negedge clk);
        signed_div = 1'b0; op1 = 32'd1000; op2 = 32'd3; start = 1'b1;
        @(posedge clk);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (ready) saw_ready = 1'b1;
        end
        annul = 1'b1;
        @(posedge clk);
        #1;
        if (ready) saw_ready = 1'b1;
        total++;
        if (saw_ready !== 1'b0 || result !== '0)
            $display("FAIL annul: saw_ready=%b result=%h, expected 0/0", saw_ready, result);
        else passed++;
        do_div(1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 33, "restart_9_3");
    endtask

    task automatic test_overflow();
        do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, 33, "div_ovf");
        do_div(1'b0, 32'hFFFF_FFFF, 32'd1, {32'd0, 32'hFFFF_FFFF}, 33, "divu_max_1");
    endtask

    task automatic test_async_reset();
        logic timeout;
        // Reset while holding a finished result.
        @(negedge clk);
        signed_div = 1'b0; op1 = 32'd100; op2 = 32'd7; start = 1'b1;
        timeout = 1'b1;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (ready) begin
                timeout = 1'b0;
                break;
            end
        end
        total++;
        if (timeout)
            $display("FAIL areset_setup: ready=%b, expected 1 within bound", ready);
        else passed++;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        total++;
        if (ready !== 1'b0 || result !== '0)
            $display("FAIL areset_end: ready=%b result=%h, expected 0/0", ready, result);
        else passed++;
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        // Reset mid-divide.
        @(negedge clk);
        op1 = 32'd100; op2 = 32'd7; start = 1'b1;
        repeat (6) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        total++;
        if (ready !== 1'b0 || result !== '0)
            $display("FAIL areset_on: ready=%b result=%h, expected 0/0", ready, result);
        else passed++;
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        do_div(1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33, "after_reset_100_7");
    endtask

    initial begin
        test_reset();
        test_divu();
        test_signed();
        test_by_zero();
        test_annul();
        test_overflow();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
